// File: rtl/ula_gray_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ula_gray_pkg
// Purpose  : Shared state encoding, size defaults and Gray helpers.
// Revision : 1.0 - initial release
// ============================================================================
package ula_gray_pkg;

    localparam int W_DEFAULT  = 8;
    localparam int PW_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Operates on 32 bits so any W up to 32 can share one helper.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_step.sv
`default_nettype none
// ============================================================================
// Module   : gray_step
// Purpose  : Combinational next-Gray-value logic; passes q through when idle.
// Revision : 1.0 - initial release
// ============================================================================
module gray_step
    import ula_gray_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] q,
    input  logic         en,
    output logic [W-1:0] q_next
);

    logic [W-1:0] w_bin;
    logic [W-1:0] w_inc;

    // Binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < W; i++) begin
            w_bin[i] = ^(q >> i);
        end
    end

    assign w_inc  = w_bin + 1'b1;
    assign q_next = en ? W'(bin2gray(32'(w_inc))) : q;

endmodule
`default_nettype wire

// File: rtl/gray_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gray_run_ctrl
// Purpose  : Prescaled Gray counter run controller (one-shot / free-run).
// Revision : 1.0 - initial release
// ============================================================================
module gray_run_ctrl
    import ula_gray_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int PW = PW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          mode,
    input  logic [PW-1:0] presc,
    input  logic [W-1:0]  term,
    output logic [W-1:0]  q,
    output logic          busy,
    output logic          done,
    output logic          wrap
);

    localparam logic [W-1:0] c_MAX_GRAY = W'(1) << (W - 1);

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_q, w_q_nxt, w_q_step;
    logic [PW-1:0] r_pc, w_pc_nxt;
    logic          r_mode, w_mode_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [W-1:0]  r_term, w_term_nxt;
    logic          r_done, w_done_nxt;
    logic          r_wrap, w_wrap_nxt;
    logic          w_step;

    // A step is suppressed when stop coincides with it.
    assign w_step = (r_state == ST_RUN) && !stop && (r_pc == r_presc);

    gray_step #(.W(W)) u_step (
        .q      (r_q),
        .en     (w_step),
        .q_next (w_q_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_pc_nxt    = r_pc;
        w_mode_nxt  = r_mode;
        w_presc_nxt = r_presc;
        w_term_nxt  = r_term;
        w_done_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ARM;
                    w_q_nxt     = '0;
                    w_pc_nxt    = '0;
                    w_mode_nxt  = mode;
                    w_presc_nxt = presc;
                    w_term_nxt  = term;
                end
            end
            ST_ARM: begin
                // Config is captured again here so the ARM cycle values win.
                w_mode_nxt  = mode;
                w_presc_nxt = presc;
                w_term_nxt  = term;
                w_state_nxt = stop ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_step) begin
                    w_q_nxt    = w_q_step;
                    w_pc_nxt   = '0;
                    w_done_nxt = (w_q_step == r_term);
                    w_wrap_nxt = (r_q == c_MAX_GRAY);
                    if ((w_q_step == r_term) && !r_mode) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_pc_nxt = r_pc + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_pc    <= '0;
            r_mode  <= 1'b0;
            r_presc <= '0;
            r_term  <= '0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_pc    <= w_pc_nxt;
            r_mode  <= w_mode_nxt;
            r_presc <= w_presc_nxt;
            r_term  <= w_term_nxt;
            r_done  <= w_done_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign q    = r_q;
    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_gray_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_run_ctrl
// Purpose  : Self-checking bench for gray_run_ctrl against a step-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_run_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, mode;
    logic [1:0] presc;
    logic [7:0] term;
    logic [7:0] q;
    logic       busy, done, wrap;

    int total = 0;
    int bad   = 0;

    // Reference model: tracks run cycles and step count, q = gray(steps mod 256).
    int         m_st;     // 0 idle, 1 arm, 2 run
    int         m_n, m_rc, m_presc;
    logic       m_mode, m_done, m_wrap;
    logic [7:0] m_q, m_term;

    always #5 clk = ~clk;

    gray_run_ctrl #(.W(8), .PW(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .presc (presc),
        .term  (term),
        .q     (q),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    task automatic tick(input logic r, input logic s, input logic p);
        int nm;
        rst = r; start = s; stop = p;
        @(posedge clk);
        m_done = 1'b0;
        m_wrap = 1'b0;
        if (rst) begin
            m_st = 0; m_q = '0; m_n = 0; m_rc = 0;
            m_mode = 1'b0; m_presc = 0; m_term = '0;
        end else begin
            case (m_st)
                0: if (start) begin
                    m_st = 1; m_q = '0; m_n = 0; m_rc = 0;
                    m_mode = mode; m_presc = int'(presc); m_term = term;
                end
                1: begin
                    m_mode = mode; m_presc = int'(presc); m_term = term;
                    m_st = stop ? 0 : 2;
                end
                default: if (stop) begin
                    m_st = 0;
                end else begin
                    m_rc++;
                    if (m_rc % (m_presc + 1) == 0) begin
                        m_n++;
                        nm     = m_n % 256;
                        m_q    = 8'(nm ^ (nm >> 1));
                        m_done = (m_q == m_term);
                        m_wrap = (nm == 0);
                        if (m_done && !m_mode) m_st = 0;
                    end
                end
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        mode = 1'b1; presc = 2'd3; term = 8'hAA;
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        total++;
        if ({busy, done, wrap, q} !== 11'h000) begin
            bad++;
            $display("FAIL reset: busy/done/wrap/q=%b/%b/%b/%h need 0/0/0/00", busy, done, wrap, q);
        end
    endtask

    task automatic test_basic();
        logic [7:0] eq [4] = '{8'h00, 8'h00, 8'h01, 8'h03};
        logic       eb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic       ed [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        mode = 1'b0; presc = 2'd0; term = 8'h03;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, i == 0, 1'b0);
            total++;
            if ({busy, done, q} !== {eb[i], ed[i], eq[i]}) begin
                bad++;
                $display("FAIL basic e%0d: busy/done/q=%b/%b/%h need %b/%b/%h",
                         i, busy, done, q, eb[i], ed[i], eq[i]);
            end
        end
    endtask

    task automatic test_presc2();
        mode = 1'b0; presc = 2'd2; term = 8'h01;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, i == 0, 1'b0);
            total++;
            if ({busy, done, wrap, q} !== {m_st != 0, m_done, m_wrap, m_q} ||
                (i == 4 && {done, q} !== {1'b1, 8'h01})) begin
                bad++;
                $display("FAIL presc2 e%0d: busy/done/wrap/q=%b/%b/%b/%h need %b/%b/%b/%h",
                         i, busy, done, wrap, q, m_st != 0, m_done, m_wrap, m_q);
            end
        end
    endtask

    task automatic test_term0_wrap();
        int  seen = -1;
        mode = 1'b0; presc = 2'd0; term = 8'h00;
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 300 && seen < 0; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            total++;
            if ({busy, done, wrap, q} !== {m_st != 0, m_done, m_wrap, m_q}) begin
                bad++;
                $display("FAIL term0 e%0d: busy/done/wrap/q=%b/%b/%b/%h need %b/%b/%b/%h",
                         i, busy, done, wrap, q, m_st != 0, m_done, m_wrap, m_q);
            end
            if (done) seen = i;
        end
        total++;
        if (seen != 257 || m_n != 256) begin
            bad++;
            $display("FAIL term0_done_at: edge=%0d steps=%0d need edge=257 steps=256", seen, m_n);
        end
    endtask

    task automatic test_freerun();
        int nd = 0, nw = 0, nb = 0;
        mode = 1'b1; presc = 2'd0; term = 8'h02;
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 600; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            nd += int'(done); nw += int'(wrap); nb += int'(!busy);
            total++;
            if ({busy, done, wrap, q} !== {m_st != 0, m_done, m_wrap, m_q}) begin
                bad++;
                $display("FAIL freerun e%0d: busy/done/wrap/q=%b/%b/%b/%h need %b/%b/%b/%h",
                         i, busy, done, wrap, q, m_st != 0, m_done, m_wrap, m_q);
            end
        end
        total++;
        if (nd != 3 || nw != 2 || nb != 0) begin
            bad++;
            $display("FAIL freerun_counts: done=%0d wrap=%0d idle=%0d need 3/2/0", nd, nw, nb);
        end
        tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stop_on_step();
        mode = 1'b0; presc = 2'd0; term = 8'h03;
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        total++;
        if ({busy, done, q} !== {1'b0, 1'b0, 8'h01}) begin
            bad++;
            $display("FAIL stop_step: busy/done/q=%b/%b/%h need 0/0/01", busy, done, q);
        end
    endtask

    task automatic test_rst_mid();
        int guard = 0;
        mode = 1'b1; presc = 2'd0; term = 8'hFF;
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        total++;
        if ({busy, q} !== {1'b1, m_q} || m_st != 2) begin
            bad++;
            $display("FAIL start_busy: busy/q=%b/%h need 1/%h", busy, q, m_q);
        end
        while (q !== 8'h06 && guard < 20) begin
            tick(1'b0, 1'b0, 1'b0);
            guard++;
        end
        total++;
        if (q !== 8'h06) begin
            bad++;
            $display("FAIL reach_06: q=%h need 06", q);
        end
        tick(1'b1, 1'b0, 1'b0);
        total++;
        if ({busy, q} !== {1'b0, 8'h00}) begin
            bad++;
            $display("FAIL rst_mid: busy/q=%b/%h need 0/00", busy, q);
        end
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        total++;
        if ({busy, done, q} !== {1'b0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL stop_idle: busy/done/q=%b/%b/%h need 0/0/00", busy, done, q);
        end
    endtask

    task automatic test_random();
        logic [31:0] rv;
        logic        r, s, p;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 59) == 0);
            // Config stays stable across the start and ARM cycles.
            if (m_st == 2 || (m_st == 0 && !s)) begin
                rv = $urandom;
                mode = rv[0]; presc = rv[2:1]; term = rv[10:3];
            end
            tick(r, s, p);
            total++;
            if ({busy, done, wrap, q} !== {m_st != 0, m_done, m_wrap, m_q}) begin
                bad++;
                $display("FAIL random c%0d: busy/done/wrap/q=%b/%b/%b/%h need %b/%b/%b/%h",
                         i, busy, done, wrap, q, m_st != 0, m_done, m_wrap, m_q);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        mode = 1'b0; presc = '0; term = '0;
        m_st = 0; m_n = 0; m_rc = 0; m_presc = 0;
        m_mode = 1'b0; m_done = 1'b0; m_wrap = 1'b0; m_q = '0; m_term = '0;
        test_reset();
        test_basic();
        test_presc2();
        test_term0_wrap();
        test_freerun();
        test_stop_on_step();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
